waveform_sweep_ctrl: RTL and testbench
======================================

# waveform_sweep_ctrl

Ping-pong sample buffer and sweep scheduler for the scrolling heart-signal display. It accepts 8-bit samples from the acquisition path and fills a back bank of one-sample-per-column memory. At frame start it swaps the back bank to the front, and serves the front bank to the waveform renderer column by column using the VGA `hcount`. Swapping only at frame boundaries keeps each displayed frame tear-free. The block sits between the sample source and the top-level display module.

## Interface
Parameters:
- `H_ACTIVE`, 1024: displayed columns, which is also the depth of each bank.
- `ADDR_W`, 10: bank address width, equal to clog2(H_ACTIVE).
- `DECIM`, 1: keep one of every DECIM accepted samples (1..255).
- `TRIG_LEVEL`, 8'd128: trigger threshold (used only with `SWEEP_TRIGGER_EN`).

Ports:
- `clk`  in  1  pixel clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `sample_valid`  in  1  `sample_in` is valid this cycle.
- `sample_in`  in  8  unsigned sample.
- `sample_ready`  out  1  block accepts the sample this cycle.
- `frame_start`  in  1  one-cycle pulse at the first blanking line after the active area.
- `freeze`  in  1  inhibits swaps; the display holds its current frame.
- `hcount`  in  11  current VGA column.
- `signal_out`  out  8  sample for column `signal_col`.
- `signal_col`  out  11  `hcount` delayed one cycle.
- `display_valid`  out  1  the front bank holds a complete sweep.
- `drop_cnt`  out  16  saturating count of samples offered while `sample_ready` is 0.

## Operation
- Storage: two banks of H_ACTIVE×8 with synchronous read. `front` is a 1-bit register that selects the read bank; the write bank is `~front`.
- States:
  - `ARM` is present only with `SWEEP_TRIGGER_EN`.
  - `FILL`: `sample_ready`=1. Each accepted sample advances the decimation counter `dcnt` (0..DECIM-1). When `dcnt`==0, the sample is written at `wr_ptr` and `wr_ptr` increments.
  - On the write at `wr_ptr`==H_ACTIVE-1, the block goes to `FULL` and `wr_ptr` wraps to 0.
  - `FULL`: `sample_ready`=0. Offered samples increment `drop_cnt`, saturating at 16'hFFFF.
  - Swap rule: when `frame_start`=1, the state is `FULL` and `freeze`=0, the block toggles `front`, sets `display_valid`=1, and goes to `FILL` (or `ARM`) with `dcnt`=0.
- Readout: when `hcount` < H_ACTIVE, the front bank is read at `hcount[ADDR_W-1:0]` and the data appears on `signal_out` the next cycle. When `hcount` ≥ H_ACTIVE or `display_valid`=0, `signal_out` is 8'd0.
- Writes never target the front bank, so no read/write collision is possible.

## Timing
- Reset values:
  - state = `FILL` (or `ARM`).
  - `front`=0, `wr_ptr`=0, `dcnt`=0.
  - `display_valid`=0, `signal_out`=0, `signal_col`=0.
  - `drop_cnt`=0.
  - `sample_ready` follows the state (1 in `FILL` and `ARM`).
- RAM contents are not cleared by reset. A reset mid-fill discards the partial sweep, and `display_valid` returns to 0 until the next swap.
- Read latency is 1 cycle: `signal_out` and `signal_col` update together.
- `sample_ready` is a registered function of the state. An accepted sample is a cycle with `sample_valid` && `sample_ready`.
- Final write and `frame_start` in the same cycle: no swap. The state becomes `FULL` and the swap happens at the next `frame_start`.
- `freeze`=1 at `frame_start`: no swap. The block stays in `FULL` and keeps dropping samples.
- A `frame_start` pulse in `FILL` or `ARM` is ignored.
- Swap is atomic within one cycle. The read in the swap cycle uses the old `front`; from the next cycle reads use the new `front`.

## Configuration
- `SWEEP_TRIGGER_EN` defined:
  - After each swap and after reset, the block enters `ARM`, where accepted samples are discarded (not counted as drops).
  - It moves to `FILL` on an accepted sample ≥ TRIG_LEVEL whose previous accepted sample was < TRIG_LEVEL. That triggering sample is written at address 0.
  - The previous-sample register resets to 8'hFF so that a constant high input never triggers.
- Undefined: there is no `ARM` state. Sweeps are free-running, and filling restarts immediately after each swap.

## Test plan
- Reset, DECIM=1, feed 1024 ramp samples 0..255 repeating, then pulse `frame_start` → `display_valid`=1 one cycle later; `hcount`=5 yields `signal_out`=5 and `signal_col`=5 one cycle later; `hcount`=1100 yields 0.
- Keep offering samples after `FULL` for 10 cycles → `sample_ready`=0 and `drop_cnt`=10; with 70000 drops, `drop_cnt`=65535.
- `freeze`=1 across two `frame_start` pulses → `front` unchanged and output frame unchanged; release `freeze` → swap at the next pulse.
- Final write coincident with `frame_start` → no swap; swap at the next pulse. Assert `reset_n` low at `wr_ptr`=500 → all outputs return to their reset values and `display_valid`=0.
- DECIM=4 with 4096 samples of value k=index → column c reads 4c[7:0].
- With `SWEEP_TRIGGER_EN`: the input 10,200,100,130,… (TRIG_LEVEL=128) → the first written sample is 200 at address 0; a constant 200 input never leaves `ARM`.

Source files
------------

// File: rtl/waveform_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : waveform_sweep_ctrl
// Description : Ping-pong sample buffer and sweep scheduler for the scrolling
//               heart-signal display. Samples fill the back bank. At a frame
//               boundary the back bank is swapped to the front. The front bank
//               is then served to the renderer column by column via hcount.
//               Optional feature macro: SWEEP_TRIGGER_EN (level-crossing
//               trigger that arms each sweep before filling starts).
// Revision    : 1.0 - initial release
// ============================================================================
module waveform_sweep_ctrl #(
  parameter int         H_ACTIVE   = 1024,
  parameter int         ADDR_W     = 10,
  parameter int         DECIM      = 1,
  parameter logic [7:0] TRIG_LEVEL = 8'd128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sample_valid,
  input  logic [7:0]  sample_in,
  output logic        sample_ready,
  input  logic        frame_start,
  input  logic        freeze,
  input  logic [10:0] hcount,
  output logic [7:0]  signal_out,
  output logic [10:0] signal_col,
  output logic        display_valid,
  output logic [15:0] drop_cnt
);

  localparam logic [10:0]       c_h_active   = 11'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [7:0]        c_decim_last = 8'(DECIM - 1);

`ifdef SWEEP_TRIGGER_EN
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1,
    ST_ARM  = 2'd2
  } state_t;
  // Every new sweep waits for a trigger crossing before it starts filling.
  localparam state_t c_st_restart = ST_ARM;
`else
  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_FULL = 2'd1
  } state_t;
  // Free-running sweeps restart filling immediately.
  localparam state_t c_st_restart = ST_FILL;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_sample_ready;
  logic              r_front;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [7:0]        r_dcnt;
  logic              r_display_valid;
  logic [15:0]       r_drop_cnt;
  logic              r_rd_en;
  logic              r_rd_sel;
  logic [10:0]       r_signal_col;
  logic [7:0]        r_rd0;
  logic [7:0]        r_rd1;
  logic [7:0]        r_bank0 [H_ACTIVE];
  logic [7:0]        r_bank1 [H_ACTIVE];

  logic              w_accept;
  logic              w_wr_en;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [7:0]        w_dcnt_nxt;
  logic [7:0]        w_dcnt_adv;
  logic              w_front_nxt;
  logic              w_dv_nxt;
  logic              w_drop_inc;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_accept   = sample_valid && r_sample_ready;
  assign w_dcnt_adv = (r_dcnt == c_decim_last) ? 8'd0 : r_dcnt + 8'd1;
  assign w_rd_addr  = hcount[ADDR_W-1:0];

`ifdef SWEEP_TRIGGER_EN
  logic [7:0] r_prev;
  logic       w_trig_hit;

  // Last accepted sample; starts high so a constant high input never crosses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= 8'hFF;
    end else if (w_accept) begin
      r_prev <= sample_in;
    end
  end

  assign w_trig_hit = (sample_in >= TRIG_LEVEL) && (r_prev < TRIG_LEVEL);
`else
  logic w_unused_trig;
  assign w_unused_trig = ^TRIG_LEVEL;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_st_restart;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic plus write / swap / drop control.
  always_comb begin
    w_state_nxt  = r_state;
    w_wr_en      = 1'b0;
    w_wr_ptr_nxt = r_wr_ptr;
    w_dcnt_nxt   = r_dcnt;
    w_front_nxt  = r_front;
    w_dv_nxt     = r_display_valid;
    w_drop_inc   = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          w_dcnt_nxt = w_dcnt_adv;
          // Only the first sample of each decimation group is stored.
          if (r_dcnt == 8'd0) begin
            w_wr_en = 1'b1;
            if (r_wr_ptr == c_last_addr) begin
              w_wr_ptr_nxt = '0;
              w_state_nxt  = ST_FULL;
            end else begin
              w_wr_ptr_nxt = r_wr_ptr + 1'b1;
            end
          end
        end
      end
      ST_FULL: begin
        // sample_ready is low here, so any offered sample is lost.
        w_drop_inc = sample_valid;
        if (frame_start && !freeze) begin
          w_front_nxt = ~r_front;
          w_dv_nxt    = 1'b1;
          w_dcnt_nxt  = 8'd0;
          w_state_nxt = c_st_restart;
        end
      end
`ifdef SWEEP_TRIGGER_EN
      ST_ARM: begin
        // The triggering sample becomes column 0; wr_ptr is 0 on entry here.
        if (w_accept && w_trig_hit) begin
          w_wr_en      = 1'b1;
          w_wr_ptr_nxt = r_wr_ptr + 1'b1;
          w_dcnt_nxt   = w_dcnt_adv;
          w_state_nxt  = ST_FILL;
        end
      end
`endif
      default: begin
        w_state_nxt = c_st_restart;
      end
    endcase
  end

  // Control and readout registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sample_ready  <= 1'b1;
      r_front         <= 1'b0;
      r_wr_ptr        <= '0;
      r_dcnt          <= 8'd0;
      r_display_valid <= 1'b0;
      r_drop_cnt      <= 16'd0;
      r_rd_en         <= 1'b0;
      r_rd_sel        <= 1'b0;
      r_signal_col    <= 11'd0;
    end else begin
      r_sample_ready  <= (w_state_nxt != ST_FULL);
      r_front         <= w_front_nxt;
      r_wr_ptr        <= w_wr_ptr_nxt;
      r_dcnt          <= w_dcnt_nxt;
      r_display_valid <= w_dv_nxt;
      if (w_drop_inc && (r_drop_cnt != 16'hFFFF)) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      // Bank select is captured with the read so a swap never mixes frames.
      r_rd_en      <= r_display_valid && (hcount < c_h_active);
      r_rd_sel     <= r_front;
      r_signal_col <= hcount;
    end
  end

  // Bank 0: written only while bank 1 is in front; synchronous read.
  always_ff @(posedge clk) begin
    if (w_wr_en && r_front) begin
      r_bank0[r_wr_ptr] <= sample_in;
    end
    r_rd0 <= r_bank0[w_rd_addr];
  end

  // Bank 1: written only while bank 0 is in front; synchronous read.
  always_ff @(posedge clk) begin
    if (w_wr_en && !r_front) begin
      r_bank1[r_wr_ptr] <= sample_in;
    end
    r_rd1 <= r_bank1[w_rd_addr];
  end

  assign signal_out    = r_rd_en ? (r_rd_sel ? r_rd1 : r_rd0) : 8'd0;
  assign signal_col    = r_signal_col;
  assign sample_ready  = r_sample_ready;
  assign display_valid = r_display_valid;
  assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_waveform_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_waveform_sweep_ctrl
// Description : Self-checking bench for waveform_sweep_ctrl. Stimulus pushes
//               expected values into a cycle-stamped scoreboard; a monitor
//               pops and compares them against the DUT outputs.
//               Honours SWEEP_TRIGGER_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_waveform_sweep_ctrl;

  localparam int K_OUT   = 0;
  localparam int K_COL   = 1;
  localparam int K_DV    = 2;
  localparam int K_RDY   = 3;
  localparam int K_DROP  = 4;
  localparam int K4_OUT  = 5;
  localparam int K4_COL  = 6;
  localparam int K4_DV   = 7;
  localparam int K4_DROP = 8;

  typedef struct {
    int cyc;
    int kind;
    int val;
    int tag;
  } exp_t;

  logic        clk;
  logic        reset_n;
  logic        sample_valid;
  logic [7:0]  sample_in;
  logic        sample_ready;
  logic        frame_start;
  logic        freeze;
  logic [10:0] hcount;
  logic [7:0]  signal_out;
  logic [10:0] signal_col;
  logic        display_valid;
  logic [15:0] drop_cnt;

  logic        sample_valid4;
  logic [7:0]  sample_in4;
  logic        sample_ready4;
  logic        frame_start4;
  logic        freeze4;
  logic [10:0] hcount4;
  logic [7:0]  signal_out4;
  logic [10:0] signal_col4;
  logic        display_valid4;
  logic [15:0] drop_cnt4;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   tag_n = 0;
  exp_t sb_q[$];
  exp_t m_e;
  int   m_act;

  waveform_sweep_ctrl #(.H_ACTIVE(1024), .ADDR_W(10), .DECIM(1), .TRIG_LEVEL(8'd128)) dut (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid), .sample_in(sample_in),
    .sample_ready(sample_ready), .frame_start(frame_start), .freeze(freeze), .hcount(hcount),
    .signal_out(signal_out), .signal_col(signal_col), .display_valid(display_valid),
    .drop_cnt(drop_cnt)
  );

  waveform_sweep_ctrl #(.H_ACTIVE(1024), .ADDR_W(10), .DECIM(4), .TRIG_LEVEL(8'd128)) dut4 (
    .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid4), .sample_in(sample_in4),
    .sample_ready(sample_ready4), .frame_start(frame_start4), .freeze(freeze4), .hcount(hcount4),
    .signal_out(signal_out4), .signal_col(signal_col4), .display_valid(display_valid4),
    .drop_cnt(drop_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(input int k);
    case (k)
      K_OUT:   return "signal_out";
      K_COL:   return "signal_col";
      K_DV:    return "display_valid";
      K_RDY:   return "sample_ready";
      K_DROP:  return "drop_cnt";
      K4_OUT:  return "decim4_signal_out";
      K4_COL:  return "decim4_signal_col";
      K4_DV:   return "decim4_display_valid";
      K4_DROP: return "decim4_drop_cnt";
      default: return "unknown";
    endcase
  endfunction

  function automatic int actual(input int k);
    case (k)
      K_OUT:   return int'(signal_out);
      K_COL:   return int'(signal_col);
      K_DV:    return int'(display_valid);
      K_RDY:   return int'(sample_ready);
      K_DROP:  return int'(drop_cnt);
      K4_OUT:  return int'(signal_out4);
      K4_COL:  return int'(signal_col4);
      K4_DV:   return int'(display_valid4);
      K4_DROP: return int'(drop_cnt4);
      default: return -1;
    endcase
  endfunction

  // Monitor: compare every expectation due at this cycle, away from the edge.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      m_e   = sb_q.pop_front();
      m_act = actual(m_e.kind);
      checks++;
      if (m_e.cyc != cyc || m_act != m_e.val) begin
        failures++;
        $display("FAIL %s tag=%0d cyc=%0d due=%0d actual=%0d required=%0d",
                 kname(m_e.kind), m_e.tag, cyc, m_e.cyc, m_act, m_e.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue an expectation lat cycles from now, kept sorted by due cycle.
  task automatic push(input int lat, input int kind, input int val);
    exp_t e;
    int   i;
    e.cyc  = cyc + lat;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag_n;
    tag_n++;
    i = 0;
    while (i < sb_q.size() && sb_q[i].cyc <= e.cyc) i++;
    sb_q.insert(i, e);
  endtask

  task automatic offer(input logic [7:0] v);
    sample_valid = 1'b1;
    sample_in    = v;
    step();
    sample_valid = 1'b0;
  endtask

  // mode 0: ramp, 1: inverted ramp, 2: ramp xor 5A, 3: constant 200
  task automatic feed(input int n, input int mode);
    logic [7:0] v;
    for (int i = 0; i < n; i++) begin
      v = 8'(i);
      case (mode)
        1:       v = 8'd255 - v;
        2:       v = v ^ 8'h5A;
        3:       v = 8'd200;
        default: v = v;
      endcase
      sample_valid = 1'b1;
      sample_in    = v;
      step();
    end
    sample_valid = 1'b0;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic rd(input int h, input int val);
    hcount = 11'(h);
    push(1, K_OUT, val);
    push(1, K_COL, h);
    step();
  endtask

  task automatic rd4(input int h, input int val);
    hcount4 = 11'(h);
    push(1, K4_OUT, val);
    push(1, K4_COL, h);
    step();
  endtask

  task automatic check_reset_vals();
    push(0, K_OUT, 0);
    push(0, K_COL, 0);
    push(0, K_DV, 0);
    push(0, K_DROP, 0);
    push(0, K_RDY, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    sample_valid = 1'b0; sample_in = 8'd0; frame_start = 1'b0; freeze = 1'b0; hcount = 11'd0;
    sample_valid4 = 1'b0; sample_in4 = 8'd0; frame_start4 = 1'b0; freeze4 = 1'b0; hcount4 = 11'd0;
    step();
    step();
    check_reset_vals();
    checks++;
    if (display_valid !== 1'b0) begin
      failures++;
      $display("FAIL display_valid in reset actual=%0b required=0", display_valid);
    end
    checks++;
    if (drop_cnt !== 16'd0) begin
      failures++;
      $display("FAIL drop_cnt in reset actual=%0d required=0", drop_cnt);
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      failures++;
      $display("FAIL sample_ready in reset actual=%0b required=1", sample_ready);
    end
    checks++;
    if (signal_out !== 8'd0 || signal_col !== 11'd0) begin
      failures++;
      $display("FAIL signal_out/signal_col in reset actual=%0d/%0d required=0/0",
               signal_out, signal_col);
    end
    step();
    reset_n = 1'b1;
    step();

`ifdef SWEEP_TRIGGER_EN
    // Constant high input never crosses the trigger level.
    feed(1100, 3);
    push(0, K_RDY, 1);
    push(1, K_DV, 0);
    pulse_fs();
    rd(5, 0);
    // 10,200,100,130 then 4..1024: trigger on 200 at address 0.
    offer(8'd10);
    offer(8'd200);
    offer(8'd100);
    offer(8'd130);
    for (int j = 4; j <= 1024; j++) offer(8'(j));
    push(0, K_RDY, 0);
    push(1, K_DV, 1);
    pulse_fs();
    rd(0, 200);
    rd(1, 100);
    rd(2, 130);
    rd(3, 4);
    rd(1023, 0);
`else
    // Fill one sweep with a ramp, then offer 10 samples into FULL.
    feed(1024, 0);
    sample_valid = 1'b1;
    for (int i = 0; i < 10; i++) step();
    sample_valid = 1'b0;
    push(0, K_RDY, 0);
    push(0, K_DROP, 10);
    push(1, K_DV, 1);
    push(1, K_RDY, 1);
    pulse_fs();
    rd(5, 5);
    rd(1100, 0);
    rd(0, 0);
    rd(300, 44);
    rd(1023, 255);

    // Second sweep (inverted ramp) into the back bank, then saturate drops.
    feed(1024, 1);
    sample_valid = 1'b1;
    for (int i = 0; i < 65600; i++) step();
    sample_valid = 1'b0;
    push(0, K_DROP, 65535);
    rd(5, 5);

    // Frozen frame_start pulses do not swap.
    freeze = 1'b1;
    pulse_fs();
    step();
    pulse_fs();
    rd(5, 5);
    rd(1023, 255);
    push(0, K_DV, 1);
    push(0, K_RDY, 0);
    freeze = 1'b0;
    step();
    pulse_fs();
    rd(5, 250);
    rd(1023, 0);
    push(0, K_RDY, 1);

    // Final write coincident with frame_start: no swap until the next pulse.
    feed(1023, 2);
    sample_valid = 1'b1;
    sample_in    = 8'hFF ^ 8'h5A;
    frame_start  = 1'b1;
    step();
    sample_valid = 1'b0;
    frame_start  = 1'b0;
    push(0, K_RDY, 0);
    rd(5, 250);
    pulse_fs();
    rd(5, 95);
    rd(1023, 165);

    // Reset in the middle of a fill.
    feed(500, 0);
    hcount  = 11'd5;
    reset_n = 1'b0;
    check_reset_vals();
    step();
    reset_n = 1'b1;
    step();
    rd(5, 0);
    push(0, K_DV, 0);

    // Decimate by 4: 4096 samples of value index, last 3 are dropped.
    for (int k = 0; k < 4096; k++) begin
      sample_valid4 = 1'b1;
      sample_in4    = 8'(k);
      step();
    end
    sample_valid4 = 1'b0;
    push(0, K4_DROP, 3);
    push(1, K4_DV, 1);
    frame_start4 = 1'b1;
    step();
    frame_start4 = 1'b0;
    rd4(1, 4);
    rd4(70, 24);
    rd4(1023, 252);
    rd4(0, 0);
`endif

    step();
    step();
    step();
    while (sb_q.size() > 0) begin
      m_e = sb_q.pop_front();
      checks++;
      failures++;
      $display("FAIL %s tag=%0d actual=unchecked required=%0d", kname(m_e.kind), m_e.tag, m_e.val);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
